// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ requesters, the arbiter and one uart_tx sink.
// A byte moves on a cycle where valid and ready are both high; valid/data/last hold until then.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ requesters,
// with an idle watchdog that revokes a grant whose owner stops presenting bytes mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int IDLE_BYTES      = 4,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout,
  output logic               state_dbg
);

  localparam int TIMEOUT_CYCLES = IDLE_BYTES * 10 * (CLOCK_FREQUENCY / BAUD_RATE);
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr, rr_n, grant_n, pick, next_g;
  logic [CNT_W-1:0]    stall_cnt, stall_n;
  logic                timeout_n;
  logic                pick_any;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]  rot;
  logic [ID_W:0]       sum;
  logic                active, own_valid, own_last, hs;

  // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit is the winner.
  always_comb begin
    dbl      = {bus.req_valid, bus.req_valid} >> rr_ptr;
    rot      = dbl[NUM_REQ-1:0];
    pick_any = |rot;
    sum      = {1'b0, rr_ptr};
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) sum = {1'b0, rr_ptr} + (ID_W+1)'(j);
    end
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    pick = sum[ID_W-1:0];
  end

  assign next_g    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign own_valid = bus.req_valid[grant_id];
  assign own_last  = bus.req_last[grant_id];

  // Reset masks the pass-through so nothing is accepted in a reset cycle.
  assign active        = (state == GRANT) && !rst;
  assign hs            = active && own_valid && bus.tx_ready;
  assign bus.tx_valid  = active && own_valid;
  assign bus.tx_data   = bus.req_data[{grant_id, 3'b000} +: 8];
  assign bus.req_ready = (active && bus.tx_ready) ? (NUM_REQ'(1) << grant_id) : '0;

  assign busy      = (state == GRANT);
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    grant_n   = grant_id;
    rr_n      = rr_ptr;
    stall_n   = stall_cnt;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_n = pick;
          stall_n = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          stall_n = '0;
          if (own_last) begin
            state_n = IDLE;
            rr_n    = next_g;
          end
        end else if (!own_valid) begin
          // Only an absent owner ages the watchdog; UART backpressure holds it.
          if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_n   = IDLE;
            rr_n      = next_g;
            stall_n   = '0;
            timeout_n = 1'b1;
          end else begin
            stall_n = stall_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      grant_id  <= grant_n;
      stall_cnt <= stall_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, a scoreboard of
// {grant_id, byte} in expected transmit order, and status checks at key cycles.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  logic [ID_W-1:0] grant_id;
  logic            busy, timeout, state_dbg;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  logic [8:0] src_mem [NUM_REQ][32];
  int         src_rd  [NUM_REQ] = '{default: 0};
  int         src_wr  [NUM_REQ] = '{default: 0};
  logic       force_all = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_srcs();
    logic [NUM_REQ-1:0]   v, l;
    logic [NUM_REQ*8-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        v[i]         = 1'b1;
        l[i]         = src_mem[i][src_rd[i]][8];
        d[i*8 +: 8]  = src_mem[i][src_rd[i]][7:0];
      end
    end
    bus.req_valid = v | {NUM_REQ{force_all}};
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_wr[r]] = {l, d};
    src_wr[r]++;
    exp_q.push_back({ID_W'(r), d});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM_REQ; i++) if (src_rd[i] < src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drv();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_busy(input string name);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (busy) break;
    end
    check(name, busy, 1);
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && srcs_empty()) break;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  // Byte sources: advance past a byte once the arbiter has acknowledged it.
  initial begin
    logic [NUM_REQ-1:0] hs;
    drive_srcs();
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (hs[i]) src_rd[i]++;
      drive_srcs();
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h expected=none", {grant_id, bus.tx_data});
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {grant_id, bus.tx_data}, e);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL global_time_limit actual=expired expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int tcount;
    int n;

    // Reset with every requester asserting.
    rst = 1'b1;
    force_all = 1'b1;
    bus.tx_ready = 1'b1;
    drive_srcs();
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_req_ready", bus.req_ready, 0);
    end
    drv();
    rst = 1'b0;
    force_all = 1'b0;
    drive_srcs();

    // Single requester, two-byte packet.
    drv();
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b1);
    wait_busy("single_busy");
    check("single_grant_id", grant_id, 2);
    @(negedge clk);
    check("single_busy_mid", busy, 1);
    @(negedge clk);
    check("single_busy_after_last", busy, 0);
    check("single_grant_hold", grant_id, 2);
    check("single_rr_ptr", dut.rr_ptr, 3);
    wait_done("single");

    // Round robin from rr_ptr=0; requester 0 re-requests immediately and must yield.
    drv();
    rst = 1'b1;
    drv();
    rst = 1'b0;
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
    push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
    push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    wait_done("rr");
    check("rr_ptr_after_rr", dut.rr_ptr, 1);

    // Packet lock: requester 1 waits for requester 0's whole packet.
    drv();
    bus.tx_ready = 1'b0;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    wait_busy("lock_busy");
    check("lock_grant_id", grant_id, 0);
    drv();
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("lock_ready1_stalled", bus.req_ready[1], 0);
      check("lock_tx_valid_stalled", bus.tx_valid, 1);
    end
    drv();
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(busy && grant_id == 0)) break;
      check("lock_ready1", bus.req_ready[1], 0);
    end
    wait_done("lock");

    // Long UART backpressure is not a stall.
    drv();
    bus.tx_ready = 1'b0;
    push(2, 8'h55, 1'b0); push(2, 8'h56, 1'b1);
    wait_busy("bp_busy");
    tcount = 0;
    repeat (50000) begin
      @(negedge clk);
      if (timeout || !busy) tcount++;
    end
    check("bp_no_timeout", tcount, 0);
    drv();
    bus.tx_ready = 1'b1;
    wait_done("bp");

    // Watchdog: owner 3 goes silent after one byte; requester 1 waits behind it.
    drv();
    push(3, 8'h77, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) break;
    end
    check("wd_first_byte_seen", bus.tx_valid && bus.tx_ready, 1);
    drv();
    push(1, 8'h5A, 1'b1);
    n = 0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (timeout) break;
    end
    check("wd_timeout_cycle", n, 17361);
    check("wd_busy_released", busy, 0);
    @(negedge clk);
    check("wd_single_pulse", timeout, 0);
    check("wd_next_busy", busy, 1);
    check("wd_next_grant", grant_id, 1);
    wait_done("wd");

    // Reset mid-packet: no byte accepted during reset, IDLE on the next cycle.
    drv();
    bus.tx_ready = 1'b0;
    push(2, 8'h88, 1'b0); push(2, 8'h89, 1'b1);
    wait_busy("mid_rst_busy");
    drv();
    rst = 1'b1;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_no_ready", bus.req_ready, 0);
    check("mid_rst_no_valid", bus.tx_valid, 0);
    drv();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state_idle", state_dbg, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rr_ptr", dut.rr_ptr, 0);
    wait_done("mid_rst");

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
